// File: rtl/dmem_arbiter.sv
// Two-master data-RAM arbiter: CPU (m0) and debug/loader (m1) share one 256-word RAM, with bounded bursts.
// Latency: grant, mem_a/mem_d/mem_we combinational in the request cycle; rvalid/err/rdata registered, one cycle after gnt.
// Backpressure: a requester waits, req held high, until its gnt; the owner yields after MAX_BURST grants if the other master waits.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [7:0]  mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic [31:0] mem_spo
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t      state;
  logic        last_owner;
  logic [3:0]  burst_cnt;
  logic [7:0]  mem_a_q;

  logic        g0;
  logic        g1;
  logic        gnt_any;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Masters are big-endian, the RAM is little-endian: swap bytes both ways.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Grant decision: owner keeps the bus until it drops req or its burst is used up while the other waits.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!sys_rst) begin
      if (state == OWN0 && m0_req) begin
        if (m1_req && burst_cnt == MAX_CNT) g1 = 1'b1;
        else                                g0 = 1'b1;
      end else if (state == OWN1 && m1_req) begin
        if (m0_req && burst_cnt == MAX_CNT) g0 = 1'b1;
        else                                g1 = 1'b1;
      end else if (m0_req && m1_req) begin
        // Contention from idle or after an owner release: favour the master that did not go last.
        if (last_owner) g0 = 1'b1;
        else            g1 = 1'b1;
      end else if (m0_req) begin
        g0 = 1'b1;
      end else if (m1_req) begin
        g1 = 1'b1;
      end
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign gnt_any   = g0 | g1;
  assign sel_we    = g1 ? m1_we    : m0_we;
  assign sel_addr  = g1 ? m1_addr  : m0_addr;
  assign sel_wdata = g1 ? m1_wdata : m0_wdata;
  assign in_range  = (sel_addr[31:10] == 22'd0) && (sel_addr[1:0] == 2'd0);

  // The RAM address follows the granted master and parks on the last one when nobody is granted.
  assign mem_a  = gnt_any ? sel_addr[9:2] : mem_a_q;
  assign mem_d  = bswap(sel_wdata);
  assign mem_we = gnt_any & sel_we & in_range;

  // Arbiter state, last-owner pointer and saturating burst counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= 4'd0;
    end else if (g0) begin
      state      <= OWN0;
      last_owner <= 1'b0;
      if (state == OWN0) begin
        if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
    end else if (g1) begin
      state      <= OWN1;
      last_owner <= 1'b1;
      if (state == OWN1) begin
        if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
    end else begin
      state <= IDLE;
    end
  end

  // Hold register for the parked RAM address.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)      mem_a_q <= 8'd0;
    else if (gnt_any) mem_a_q <= sel_addr[9:2];
  end

  // Read/error responses one cycle after the grant; rdata holds between rvalids.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= 32'd0;
    end else begin
      m0_rvalid <= g0 & ~m0_we;
      m0_err    <= g0 & ~in_range;
      m1_rvalid <= g1 & ~m1_we;
      m1_err    <= g1 & ~in_range;
      if (g0 && !m0_we) m0_rdata <= in_range ? bswap(mem_spo) : 32'd0;
      if (g1 && !m1_we) m1_rdata <= in_range ? bswap(mem_spo) : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural async-read RAM.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 4 units after it.
// Vector table covers contention, read/write paths and range errors; hand sequences cover saturation and mid-burst reset.
module tb_dmem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  mem_a;
  logic [31:0] mem_d, mem_spo;
  logic        mem_we;

  logic [31:0] ram [256];
  logic        ram_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
  );

  // RAM model: preloaded with 0xA00000nn at word nn on the first edge, then synchronous write, async read.
  always @(posedge sys_clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | i;
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_a] <= mem_d;
    end
  end
  assign mem_spo = ram[mem_a];

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        eg0, eg1, ewe;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        ev0, ee0;
    logic [31:0] erd0;
    logic        ev1, ee1;
    logic [31:0] erd1;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    sys_rst = rst;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    //            rst r0 w0 a0           d0            r1 w1 a1           d1   g0 g1 we ea     ed            v0 e0 rd0           v1 e1 rd1
    tbl[0]  = '{1, 1,1,32'h10,       32'h0,        1,0,32'h0,       32'h0, 0,0,0,8'h00,32'h0,        0,0,32'h0,        0,0,32'h0};
    tbl[1]  = '{0, 1,0,32'h20,       32'h0,        1,0,32'h24,      32'h0, 1,0,0,8'h08,32'h0,        0,0,32'h0,        0,0,32'h0};
    tbl[2]  = '{0, 1,0,32'h20,       32'h0,        1,0,32'h24,      32'h0, 1,0,0,8'h08,32'h0,        1,0,32'h080000A0, 0,0,32'h0};
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = '{0, 1,0,32'h20,       32'h0,        1,0,32'h24,      32'h0, 0,1,0,8'h09,32'h0,        1,0,32'h080000A0, 0,0,32'h0};
    tbl[6]  = '{0, 1,0,32'h20,       32'h0,        1,0,32'h24,      32'h0, 0,1,0,8'h09,32'h0,        0,0,32'h080000A0, 1,0,32'h090000A0};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{0, 1,0,32'h20,       32'h0,        1,0,32'h24,      32'h0, 1,0,0,8'h08,32'h0,        0,0,32'h080000A0, 1,0,32'h090000A0};
    tbl[10] = '{0, 1,1,32'h10,       32'h11223344, 0,0,32'h0,       32'h0, 1,0,1,8'h04,32'h44332211, 1,0,32'h080000A0, 0,0,32'h090000A0};
    tbl[11] = '{0, 1,0,32'h10,       32'h0,        0,0,32'h0,       32'h0, 1,0,0,8'h04,32'h0,        0,0,32'h080000A0, 0,0,32'h090000A0};
    tbl[12] = '{0, 0,0,32'h0,        32'h0,        0,0,32'h0,       32'h0, 0,0,0,8'h04,32'h0,        1,0,32'h11223344, 0,0,32'h090000A0};
    tbl[13] = '{0, 0,0,32'h0,        32'h0,        1,0,32'h400,     32'h0, 0,1,0,8'h00,32'h0,        0,0,32'h11223344, 0,0,32'h090000A0};
    tbl[14] = '{0, 0,0,32'h0,        32'h0,        0,0,32'h0,       32'h0, 0,0,0,8'h00,32'h0,        0,0,32'h11223344, 1,1,32'h0};
    tbl[15] = '{0, 1,1,32'h2,        32'hDEADBEEF, 0,0,32'h0,       32'h0, 1,0,0,8'h00,32'h0,        0,0,32'h11223344, 0,0,32'h0};
    tbl[16] = '{0, 1,0,32'h0,        32'h0,        0,0,32'h0,       32'h0, 1,0,0,8'h00,32'h0,        0,1,32'h11223344, 0,0,32'h0};
    tbl[17] = '{0, 0,0,32'h0,        32'h0,        0,0,32'h0,       32'h0, 0,0,0,8'h00,32'h0,        1,0,32'h000000A0, 0,0,32'h0};
    tbl[18] = '{0, 0,0,32'h0,        32'h0,        1,1,32'h30,      32'hCAFEF00D, 0,1,1,8'h0C,32'h0DF0FECA, 0,0,32'h000000A0, 0,0,32'h0};
    tbl[19] = '{0, 1,0,32'h30,       32'h0,        0,0,32'h0,       32'h0, 1,0,0,8'h0C,32'h0,        0,0,32'h000000A0, 0,0,32'h0};
    tbl[20] = '{0, 0,0,32'h0,        32'h0,        0,0,32'h0,       32'h0, 0,0,0,8'h0C,32'h0,        1,0,32'hCAFEF00D, 0,0,32'h0};

    drive(1'b1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();

    for (int v = 0; v < NV; v++) begin
      drive(tbl[v].rst, tbl[v].r0, tbl[v].w0, tbl[v].a0, tbl[v].d0,
            tbl[v].r1, tbl[v].w1, tbl[v].a1, tbl[v].d1);
      #3;
      chk($sformatf("row%0d m0_gnt", v),    {31'd0, m0_gnt},    {31'd0, tbl[v].eg0});
      chk($sformatf("row%0d m1_gnt", v),    {31'd0, m1_gnt},    {31'd0, tbl[v].eg1});
      chk($sformatf("row%0d mem_we", v),    {31'd0, mem_we},    {31'd0, tbl[v].ewe});
      chk($sformatf("row%0d mem_a", v),     {24'd0, mem_a},     {24'd0, tbl[v].ea});
      if (tbl[v].ewe) chk($sformatf("row%0d mem_d", v), mem_d, tbl[v].ed);
      chk($sformatf("row%0d m0_rvalid", v), {31'd0, m0_rvalid}, {31'd0, tbl[v].ev0});
      chk($sformatf("row%0d m0_err", v),    {31'd0, m0_err},    {31'd0, tbl[v].ee0});
      chk($sformatf("row%0d m0_rdata", v),  m0_rdata,           tbl[v].erd0);
      chk($sformatf("row%0d m1_rvalid", v), {31'd0, m1_rvalid}, {31'd0, tbl[v].ev1});
      chk($sformatf("row%0d m1_err", v),    {31'd0, m1_err},    {31'd0, tbl[v].ee1});
      chk($sformatf("row%0d m1_rdata", v),  m1_rdata,           tbl[v].erd1);
      next_cycle();
    end

    // m1 alone for 10 cycles keeps the grant; m0 arriving then takes over at once (burst saturated).
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
      #3;
      chk($sformatf("solo m1 cyc%0d m1_gnt", c), {31'd0, m1_gnt}, 32'd1);
      chk($sformatf("solo m1 cyc%0d m0_gnt", c), {31'd0, m0_gnt}, 32'd0);
      next_cycle();
    end
    drive(1'b0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h40, 32'h0);
    #3;
    chk("saturated switch m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("saturated switch m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("saturated switch mem_a",  {24'd0, mem_a},  32'h11);
    next_cycle();

    // Reset on the third m0 burst grant aborts it; contention afterwards goes to m0.
    drive(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
      #3;
      chk($sformatf("burst grant%0d m0_gnt", c + 1), {31'd0, m0_gnt}, 32'd1);
      next_cycle();
    end
    drive(1'b1, 1, 1, 32'h8, 32'h55555555, 0, 0, 32'h0, 32'h0);
    #3;
    chk("reset forces m0_gnt low", {31'd0, m0_gnt}, 32'd0);
    chk("reset forces mem_we low", {31'd0, mem_we}, 32'd0);
    next_cycle();
    drive(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    #3;
    chk("after reset m0_gnt",    {31'd0, m0_gnt},    32'd0);
    chk("after reset m1_gnt",    {31'd0, m1_gnt},    32'd0);
    chk("after reset m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("after reset m0_rdata",  m0_rdata,           32'd0);
    chk("after reset mem_a",     {24'd0, mem_a},     32'd0);
    next_cycle();
    drive(1'b0, 1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
    #3;
    chk("post-reset contention m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("post-reset contention m1_gnt", {31'd0, m1_gnt}, 32'd0);
    next_cycle();
    drive(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    #3;
    chk("post-reset read m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("post-reset read m0_rdata",  m0_rdata,           32'h010000A0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
